// File: rtl/div_mode_sequencer.sv
// div_mode_sequencer: glitch-safe FMDLL divider mode sequencer (gate, reset, switch, release, lock check)
module div_mode_sequencer #(
  parameter int SETTLE_CYC  = 8,
  parameter int LOCK_EDGES  = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] m_req,
  output logic       req_ready,
  input  logic       div_clk2,
  output logic [1:0] m_sel,
  output logic       div_rst_n,
  output logic       clk_en,
  output logic       locked,
  output logic       busy,
  output logic       fault
);
  typedef enum logic [2:0] {IDLE, GATE, HOLD, SWITCH, WAIT_LOCK, FAULT} state_t;
  state_t state, state_nx;
  logic [1:0] m_pend;
  logic [7:0] settle_cnt;
  logic [3:0] edge_cnt;
  logic [11:0] tmo_cnt;
  logic s1, s2, s3;
  logic accept, edge_det, enter, settle_done, lock_hit, tmo_hit;
  logic busy_d, ready_d, run_d, drst_d, fault_d;
  assign accept      = req_valid & req_ready;
  assign edge_det    = s2 & ~s3;
  assign enter       = state_nx != state;
  assign settle_done = settle_cnt == 8'(SETTLE_CYC - 1);
  assign lock_hit    = edge_cnt >= 4'(LOCK_EDGES);
  assign tmo_hit     = tmo_cnt == 12'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HOLD;
      m_pend     <= '0;
      m_sel      <= '0;
      div_rst_n  <= 1'b0;
      clk_en     <= 1'b0;
      locked     <= 1'b0;
      busy       <= 1'b1;
      fault      <= 1'b0;
      req_ready  <= 1'b0;
      settle_cnt <= '0;
      edge_cnt   <= '0;
      tmo_cnt    <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
    end else begin
      state      <= state_nx;
      m_pend     <= accept ? m_req : m_pend;
      m_sel      <= (enter && state_nx == SWITCH) ? m_pend : m_sel;
      div_rst_n  <= drst_d;
      clk_en     <= run_d;
      locked     <= run_d;
      busy       <= busy_d;
      fault      <= fault_d;
      req_ready  <= ready_d;
      settle_cnt <= enter ? '0 : settle_cnt + 8'd1;
      s1         <= div_clk2;
      s2         <= s1;
      // Clearing the delay flop and counters on WAIT_LOCK entry discards edges seen before release
      if (enter && state_nx == WAIT_LOCK) begin
        s3       <= 1'b0;
        edge_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        s3       <= s2;
        edge_cnt <= (edge_det && edge_cnt != 4'hf) ? edge_cnt + 4'd1 : edge_cnt;
        tmo_cnt  <= tmo_cnt + 12'd1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = (accept && m_req != m_sel) ? GATE : IDLE;
      GATE:      state_nx = HOLD;
      HOLD:      state_nx = settle_done ? SWITCH : HOLD;
      SWITCH:    state_nx = settle_done ? WAIT_LOCK : SWITCH;
      WAIT_LOCK: state_nx = lock_hit ? IDLE : tmo_hit ? FAULT : WAIT_LOCK;
      FAULT:     state_nx = accept ? GATE : FAULT;
      default:   state_nx = HOLD;
    endcase
  end
  // Outputs decode the next state so they register together with the state change
  always_comb begin
    busy_d  = state_nx inside {GATE, HOLD, SWITCH, WAIT_LOCK};
    ready_d = state_nx inside {IDLE, FAULT};
    run_d   = state_nx == IDLE;
    drst_d  = state_nx inside {GATE, WAIT_LOCK, IDLE};
    fault_d = state_nx == FAULT;
  end
endmodule

// File: tb/tb_div_mode_sequencer.sv
// tb_div_mode_sequencer: directed stimulus with a cycle-stamped scoreboard and a lock-event queue
module tb_div_mode_sequencer;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic [1:0] m_req = 2'd0;
  logic div_clk2 = 1'b0;
  logic req_ready, div_rst_n, clk_en, locked, busy, fault;
  logic [1:0] m_sel;
  typedef struct {int cyc; string name; logic [7:0] exp; logic [7:0] mask;} chk_t;
  typedef struct {string name; logic [1:0] m; int deadline;} evt_t;
  chk_t tq[$];
  evt_t eq[$];
  chk_t chk;
  evt_t ev;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int guard_mode = 0;
  logic [1:0] guard_v = 2'd0;
  logic div_en = 1'b1;
  logic [1:0] dcnt = 2'd0;
  logic locked_q = 1'b0;
  logic [7:0] act;
  div_mode_sequencer #(.SETTLE_CYC(8), .LOCK_EDGES(4), .TIMEOUT_CYC(256)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .req_valid(req_valid), .m_req(m_req),
    .req_ready(req_ready), .div_clk2(div_clk2), .m_sel(m_sel), .div_rst_n(div_rst_n),
    .clk_en(clk_en), .locked(locked), .busy(busy), .fault(fault)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  // Divider model: divide-by-4 clk2, held low while the divider is in reset
  always @(negedge clk_in) begin
    if (!div_rst_n || !div_en) begin
      dcnt = 2'd0;
      div_clk2 = 1'b0;
    end else begin
      dcnt = dcnt + 2'd1;
      div_clk2 = dcnt[1];
    end
  end
  function automatic logic [7:0] v(input logic [1:0] m, input logic dr, ce, lk, bz, ft, rdy);
    return {m, dr, ce, lk, bz, ft, rdy};
  endfunction
  localparam logic [7:0] RESET_VEC = 8'b00_0_0_0_1_0_0;
  task automatic expect_at(input int c, input string nm, input logic [7:0] e);
    tq.push_back('{c, nm, e, 8'hff});
  endtask
  task automatic expect_lock(input string nm, input logic [1:0] m, input int dl);
    eq.push_back('{nm, m, dl});
  endtask
  task automatic issue(input logic [1:0] m, output int n);
    @(negedge clk_in);
    n = cyc + 1;
    req_valid = 1'b1;
    m_req = m;
  endtask
  task automatic drain;
    while (eq.size() != 0 || tq.size() != 0) @(negedge clk_in);
  endtask
  always @(negedge clk_in) begin
    act = {m_sel, div_rst_n, clk_en, locked, busy, fault, req_ready};
    while (tq.size() != 0 && tq[0].cyc <= cyc) begin
      chk = tq.pop_front();
      n_cmp++;
      if (chk.cyc != cyc || (act & chk.mask) != (chk.exp & chk.mask)) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got m_sel/drst/clken/locked/busy/fault/ready=%b want %b", chk.name, cyc, act, chk.exp);
      end
    end
    if (eq.size() != 0) begin
      if (locked && !locked_q) begin
        ev = eq.pop_front();
        n_cmp++;
        if (m_sel != ev.m || cyc > ev.deadline) begin
          n_bad++;
          $display("FAIL %s: locked at cyc %0d m_sel=%0d, want m_sel=%0d by cyc %0d", ev.name, cyc, m_sel, ev.m, ev.deadline);
        end
      end else if (cyc > eq[0].deadline) begin
        ev = eq.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no lock by cyc %0d (locked=%b), want lock in m_sel=%0d", ev.name, ev.deadline, locked, ev.m);
      end
    end
    if (guard_mode != 0) begin
      n_cmp++;
      if ((guard_mode == 1) != (m_sel == guard_v)) begin
        n_bad++;
        $display("FAIL guard @cyc %0d: m_sel=%0d, required %s %0d", cyc, m_sel, guard_mode == 1 ? "==" : "!=", guard_v);
      end
    end
    locked_q = locked;
  end
  initial begin
    int c, r, n;
    // Power-on: reset values, then automatic bring-up to mode 0
    repeat (2) @(negedge clk_in);
    expect_at(cyc + 1, "reset", RESET_VEC);
    @(negedge clk_in);
    rst_n = 1'b1;
    r = cyc;
    guard_mode = 1;
    guard_v = 2'd0;
    expect_at(r + 15, "por_drst_lo", v(0, 0, 0, 0, 1, 0, 0));
    expect_at(r + 16, "por_drst_hi", v(0, 1, 0, 0, 1, 0, 0));
    expect_lock("por_lock", 2'd0, r + 35);
    drain;
    expect_at(cyc + 1, "por_idle", v(0, 1, 1, 1, 0, 0, 1));
    drain;
    guard_mode = 0;
    // Mode change 0 -> 2
    issue(2'd2, n);
    expect_at(n, "mc_gate", v(0, 1, 0, 0, 1, 0, 0));
    expect_at(n + 1, "mc_hold", v(0, 0, 0, 0, 1, 0, 0));
    expect_at(n + 8, "mc_msel_old", v(0, 0, 0, 0, 1, 0, 0));
    expect_at(n + 9, "mc_msel_new", v(2, 0, 0, 0, 1, 0, 0));
    expect_at(n + 16, "mc_drst_lo", v(2, 0, 0, 0, 1, 0, 0));
    expect_at(n + 17, "mc_drst_hi", v(2, 1, 0, 0, 1, 0, 0));
    expect_lock("mc_lock", 2'd2, n + 36);
    @(negedge clk_in);
    req_valid = 1'b0;
    drain;
    // Same-mode request is a no-op
    issue(2'd2, n);
    expect_at(n, "same_n0", v(2, 1, 1, 1, 0, 0, 1));
    expect_at(n + 1, "same_n1", v(2, 1, 1, 1, 0, 0, 1));
    expect_at(n + 3, "same_n3", v(2, 1, 1, 1, 0, 0, 1));
    @(negedge clk_in);
    req_valid = 1'b0;
    drain;
    // Request while busy is ignored
    issue(2'd1, n);
    guard_mode = 2;
    guard_v = 2'd3;
    expect_at(n, "busy_gate", v(2, 1, 0, 0, 1, 0, 0));
    expect_at(n + 3, "busy_rdy", v(2, 0, 0, 0, 1, 0, 0));
    expect_at(n + 9, "busy_msel", v(1, 0, 0, 0, 1, 0, 0));
    expect_lock("busy_lock", 2'd1, n + 36);
    @(negedge clk_in);
    req_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    req_valid = 1'b1;
    m_req = 2'd3;
    repeat (3) @(negedge clk_in);
    req_valid = 1'b0;
    drain;
    expect_at(cyc + 1, "busy_idle1", v(1, 1, 1, 1, 0, 0, 1));
    expect_at(cyc + 4, "busy_idle4", v(1, 1, 1, 1, 0, 0, 1));
    drain;
    guard_mode = 0;
    // Lock timeout with a stopped divider, then recovery
    div_en = 1'b0;
    issue(2'd3, n);
    expect_at(n + 272, "tmo_wait", v(3, 1, 0, 0, 1, 0, 0));
    expect_at(n + 273, "tmo_fault", v(3, 0, 0, 0, 0, 1, 1));
    expect_at(n + 280, "tmo_sticky", v(3, 0, 0, 0, 0, 1, 1));
    @(negedge clk_in);
    req_valid = 1'b0;
    drain;
    div_en = 1'b1;
    issue(2'd1, n);
    expect_at(n, "rec_gate", v(3, 1, 0, 0, 1, 0, 0));
    expect_at(n + 9, "rec_msel", v(1, 0, 0, 0, 1, 0, 0));
    expect_lock("rec_lock", 2'd1, n + 36);
    @(negedge clk_in);
    req_valid = 1'b0;
    drain;
    expect_at(cyc + 1, "rec_idle", v(1, 1, 1, 1, 0, 0, 1));
    drain;
    // Reset during SWITCH toward mode 3
    issue(2'd3, n);
    expect_at(n + 10, "mr_switch", v(3, 0, 0, 0, 1, 0, 0));
    expect_at(n + 11, "mr_reset", RESET_VEC);
    expect_at(n + 12, "mr_reset_hold", RESET_VEC);
    @(negedge clk_in);
    req_valid = 1'b0;
    while (cyc < n + 10) @(negedge clk_in);
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    r = cyc;
    guard_mode = 1;
    guard_v = 2'd0;
    expect_at(r + 15, "mr_drst_lo", v(0, 0, 0, 0, 1, 0, 0));
    expect_at(r + 16, "mr_drst_hi", v(0, 1, 0, 0, 1, 0, 0));
    expect_lock("mr_lock", 2'd0, r + 35);
    drain;
    expect_at(cyc + 1, "mr_idle", v(0, 1, 1, 1, 0, 0, 1));
    drain;
    guard_mode = 0;
    @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
